// File: rtl/cache_pkg.sv
// Shared types for the cache write-back buffer: block/address widths,
// controller state encoding and the buffered entry payload.
package cache_pkg;

    localparam int unsigned BLOCK_WIDTH = 128;
    localparam int unsigned BADDR_WIDTH = 28;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_MEM = 2'd1,
        WR_MEM = 2'd2,
        RESP   = 2'd3
    } wb_state_e;

    typedef struct packed {
        logic [BADDR_WIDTH-1:0] addr;
        logic [BLOCK_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/cache_wb_buffer_if.sv
// Block-level memory port: request/address/data out, completion pulse and
// read data back. The same protocol is used on the cache side and the memory side.
interface cache_wb_buffer_if;
    import cache_pkg::*;

    logic                   read;
    logic                   write;
    logic [BADDR_WIDTH-1:0] addr;
    logic [BLOCK_WIDTH-1:0] wdata;
    logic [BLOCK_WIDTH-1:0] rdata;
    logic                   ready;

    modport master (output read, write, addr, wdata, input rdata, ready);
    modport slave  (input read, write, addr, wdata, output rdata, ready);

endinterface

// File: rtl/cache_wb_buffer_fifo.sv
// Circular queue of pending write-back blocks with a parallel address lookup
// used for read forwarding and write coalescing.
module wb_fifo
    import cache_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned IW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  wb_entry_t              push_entry,
    input  logic                   pop,
    input  logic                   cw_en,
    input  logic [IW-1:0]          cw_idx,
    input  logic [BLOCK_WIDTH-1:0] cw_data,
    input  logic [BADDR_WIDTH-1:0] lookup_addr,
    output logic                   hit_c,
    output logic [IW-1:0]          hit_idx_c,
    output logic [BLOCK_WIDTH-1:0] hit_data_c,
    output wb_entry_t              head_c,
    output logic                   full_c,
    output logic                   empty
);

    localparam int unsigned CW = IW + 1;

    wb_entry_t        entry_q [DEPTH];
    wb_entry_t        entry_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [IW-1:0]    head_q, head_d;
    logic [IW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             empty_q, empty_d;

    // Coalescing on write keeps addresses unique, so at most one entry matches.
    always_comb begin
        hit_c     = 1'b0;
        hit_idx_c = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (entry_q[i].addr == lookup_addr)) begin
                hit_c     = 1'b1;
                hit_idx_c = IW'(i);
            end
        end
    end

    assign hit_data_c = entry_q[hit_idx_c].data;
    assign head_c     = entry_q[head_q];
    assign full_c     = (count_q == CW'(DEPTH));
    assign empty      = empty_q;

    always_comb begin
        entry_d = entry_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (cw_en) begin
            entry_d[cw_idx].data = cw_data;
        end
        if (push) begin
            entry_d[tail_q] = push_entry;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + IW'(1);
            count_d         = count_d + CW'(1);
        end
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + IW'(1);
            count_d         = count_d - CW'(1);
        end
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            empty_q <= empty_d;
        end
    end

    // Payload needs no reset: valid bits gate every use of it.
    always_ff @(posedge clk) begin
        entry_q <= entry_d;
    end

endmodule

// File: rtl/cache_wb_buffer.sv
// Write-back buffer between the cache memory port and main memory: absorbs
// evictions, forwards buffered data to reads and drains when the cache is idle.
module cache_wb_buffer
    import cache_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    cache_wb_buffer_if.slave  c,
    cache_wb_buffer_if.master mem,
    output logic              wb_empty
);

    localparam int unsigned IW = $clog2(DEPTH);

    wb_state_e              state_q, state_d;
    logic                   c_ready_q, c_ready_d;
    logic [BLOCK_WIDTH-1:0] c_rdata_q, c_rdata_d;
    logic                   mem_read_q, mem_read_d;
    logic                   mem_write_q, mem_write_d;
    logic [BADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [BLOCK_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic                   push, pop, cw_en;
    logic                   hit_c, full_c, fifo_empty;
    logic [IW-1:0]          hit_idx_c;
    logic [BLOCK_WIDTH-1:0] hit_data_c;
    wb_entry_t              head_c;
    wb_entry_t              push_entry;

    assign push_entry = '{addr: c.addr, data: c.wdata};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .cw_en      (cw_en),
        .cw_idx     (hit_idx_c),
        .cw_data    (c.wdata),
        .lookup_addr(c.addr),
        .hit_c      (hit_c),
        .hit_idx_c  (hit_idx_c),
        .hit_data_c (hit_data_c),
        .head_c     (head_c),
        .full_c     (full_c),
        .empty      (fifo_empty)
    );

    // Reads beat writes, writes beat background drains; a write to a full,
    // non-matching buffer drains the head first and is re-evaluated afterwards.
    always_comb begin
        state_d     = state_q;
        c_ready_d   = 1'b0;
        c_rdata_d   = c_rdata_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        push        = 1'b0;
        pop         = 1'b0;
        cw_en       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (c.read) begin
                    if (hit_c) begin
                        c_rdata_d = hit_data_c;
                        c_ready_d = 1'b1;
                        state_d   = RESP;
                    end else begin
                        mem_read_d = 1'b1;
                        mem_addr_d = c.addr;
                        state_d    = RD_MEM;
                    end
                end else if (c.write && hit_c) begin
                    cw_en     = 1'b1;
                    c_ready_d = 1'b1;
                    state_d   = RESP;
                end else if (c.write && !full_c) begin
                    push      = 1'b1;
                    c_ready_d = 1'b1;
                    state_d   = RESP;
                end else if (c.write || !fifo_empty) begin
                    mem_write_d = 1'b1;
                    mem_addr_d  = head_c.addr;
                    mem_wdata_d = head_c.data;
                    state_d     = WR_MEM;
                end
            end
            RD_MEM: begin
                if (mem.ready) begin
                    c_rdata_d  = mem.rdata;
                    mem_read_d = 1'b0;
                    c_ready_d  = 1'b1;
                    state_d    = RESP;
                end
            end
            WR_MEM: begin
                if (mem.ready) begin
                    pop         = 1'b1;
                    mem_write_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            c_ready_q   <= 1'b0;
            c_rdata_q   <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            c_ready_q   <= c_ready_d;
            c_rdata_q   <= c_rdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign c.ready   = c_ready_q;
    assign c.rdata   = c_rdata_q;
    assign mem.read  = mem_read_q;
    assign mem.write = mem_write_q;
    assign mem.addr  = mem_addr_q;
    assign mem.wdata = mem_wdata_q;
    assign wb_empty  = fifo_empty;

endmodule

// File: tb/tb_cache_wb_buffer.sv
// Bench for cache_wb_buffer: directed scenarios then random traffic against a
// queue-plus-memory reference model and a latency-programmable memory responder.
module tb_cache_wb_buffer;
    import cache_pkg::*;

    localparam int unsigned DEPTH = 4;

    typedef logic [BADDR_WIDTH-1:0] addr_t;
    typedef logic [BLOCK_WIDTH-1:0] data_t;
    typedef struct {
        addr_t a;
        data_t d;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    logic wb_empty;

    cache_wb_buffer_if c_if ();
    cache_wb_buffer_if m_if ();

    cache_wb_buffer #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .c       (c_if),
        .mem     (m_if),
        .wb_empty(wb_empty)
    );

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    ent_t        mq[$];
    data_t       mem_store [addr_t];
    addr_t       drained[$];
    data_t       last_drain_data = '0;
    int          mem_reads   = 0;
    int          mem_writes  = 0;
    bit          mem_stall   = 1'b0;
    bit          rand_delay  = 1'b0;
    int unsigned fixed_delay = 1;

    task automatic check_eq(input string tag, input data_t got, input data_t exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic data_t init_val(input addr_t a);
        return {4{4'hC, a}};
    endfunction

    function automatic data_t mem_val(input addr_t a);
        if (mem_store.exists(a)) return mem_store[a];
        return init_val(a);
    endfunction

    function automatic int find_q(input addr_t a);
        foreach (mq[i]) if (mq[i].a == a) return i;
        return -1;
    endfunction

    // Newest cache-visible value: a buffered write if present, else memory.
    function automatic data_t expect_read(input addr_t a);
        int i;
        i = find_q(a);
        return (i >= 0) ? mq[i].d : mem_val(a);
    endfunction

    function automatic data_t rand_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    always @(posedge clk) begin
        if (!rst) assert (!(c_if.read && c_if.write))
            else $error("cache read and write requested together");
    end

    // Memory model: answers each request after a programmable delay.
    initial begin
        int unsigned dly;
        bit busy;
        dly = 0;
        busy = 1'b0;
        m_if.ready = 1'b0;
        m_if.rdata = '0;
        forever begin
            @(negedge clk);
            m_if.ready = 1'b0;
            if (rst) begin
                busy = 1'b0;
            end else if (m_if.read || m_if.write) begin
                if (!busy) begin
                    busy = 1'b1;
                    dly = rand_delay ? $urandom_range(0, 3) : fixed_delay;
                    check_eq("mem_rw_exclusive", data_t'(m_if.read & m_if.write), '0);
                    if (m_if.read)
                        check_eq("miss_not_buffered", data_t'(find_q(m_if.addr) >= 0), '0);
                end
                if (!mem_stall) begin
                    if (dly == 0) begin
                        busy = 1'b0;
                        m_if.ready = 1'b1;
                        if (m_if.read) begin
                            m_if.rdata = mem_val(m_if.addr);
                            mem_reads++;
                        end else begin
                            mem_writes++;
                            if (mq.size() == 0) begin
                                check_eq("drain_unexpected", data_t'(m_if.write), '0);
                            end else begin
                                check_eq("drain_addr", data_t'(m_if.addr), data_t'(mq[0].a));
                                check_eq("drain_data", m_if.wdata, mq[0].d);
                                void'(mq.pop_front());
                            end
                            mem_store[m_if.addr] = m_if.wdata;
                            drained.push_back(m_if.addr);
                            last_drain_data = m_if.wdata;
                        end
                    end else begin
                        dly--;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag, input int budget, output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!c_if.ready && lat < budget);
        if (!c_if.ready) check_eq({tag, "_timeout"}, data_t'(c_if.ready), data_t'(1));
    endtask

    task automatic wait_mem_req(input string tag, input bit want_read);
        int n;
        n = 0;
        while (!(want_read ? m_if.read : m_if.write) && n < 50) begin
            tick();
            n++;
        end
        check_eq(tag, data_t'(want_read ? m_if.read : m_if.write), data_t'(1));
    endtask

    task automatic do_write(input addr_t a, input data_t d, input int exp_lat);
        int lat;
        int i;
        c_if.write = 1'b1;
        c_if.addr  = a;
        c_if.wdata = d;
        wait_ready("wr", 200, lat);
        c_if.write = 1'b0;
        if (c_if.ready) begin
            if (exp_lat > 0) check_eq("wr_latency", data_t'(lat), data_t'(exp_lat));
            check_eq("wb_empty_after_wr", data_t'(wb_empty), '0);
            i = find_q(a);
            if (i >= 0) mq[i].d = d;
            else mq.push_back('{a, d});
        end
    endtask

    task automatic do_read(input addr_t a, input int exp_lat, input bit exp_hit);
        int lat;
        int rd0;
        rd0 = mem_reads;
        c_if.read = 1'b1;
        c_if.addr = a;
        wait_ready("rd", 200, lat);
        c_if.read = 1'b0;
        if (c_if.ready) begin
            check_eq("rd_data", c_if.rdata, expect_read(a));
            if (exp_lat > 0) check_eq("rd_latency", data_t'(lat), data_t'(exp_lat));
            if (exp_hit) check_eq("rd_no_mem_read", data_t'(mem_reads - rd0), '0);
        end
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (!(wb_empty && !m_if.write) && n < 300) begin
            tick();
            n++;
        end
        check_eq({tag, "_wb_empty"}, data_t'(wb_empty), data_t'(1));
        check_eq({tag, "_model_empty"}, data_t'(mq.size()), '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int wr0;
        addr_t a;
        rst = 1'b1;
        c_if.read  = 1'b0;
        c_if.write = 1'b0;
        c_if.addr  = '0;
        c_if.wdata = '0;
        repeat (2) tick();
        rst = 1'b0;
        repeat (5) tick();
        check_eq("rst_c_ready",   data_t'(c_if.ready), '0);
        check_eq("rst_c_rdata",   c_if.rdata, '0);
        check_eq("rst_mem_read",  data_t'(m_if.read), '0);
        check_eq("rst_mem_write", data_t'(m_if.write), '0);
        check_eq("rst_mem_addr",  data_t'(m_if.addr), '0);
        check_eq("rst_mem_wdata", m_if.wdata, '0);
        check_eq("rst_wb_empty",  data_t'(wb_empty), data_t'(1));

        // Single write then background drain with a 3-cycle memory.
        fixed_delay = 2;
        do_write(28'h10, {16{8'hA5}}, 1);
        wait_mem_req("t1_mem_write", 1'b0);
        check_eq("t1_mem_addr",  data_t'(m_if.addr), data_t'(28'h10));
        check_eq("t1_mem_wdata", m_if.wdata, {16{8'hA5}});
        wr0 = 0;
        while (!m_if.ready && wr0 < 20) begin
            tick();
            wr0++;
        end
        check_eq("t1_mem_ready_seen", data_t'(m_if.ready), data_t'(1));
        check_eq("t1_write_drop",     data_t'(m_if.write), '0);
        check_eq("t1_wb_empty",       data_t'(wb_empty), data_t'(1));

        // Forwarding from the buffer while memory is stalled.
        mem_stall = 1'b1;
        do_write(28'h20, {4{32'hD1D1_0020}}, 1);
        do_read(28'h20, 2, 1'b1);
        mem_stall = 1'b0;
        wait_drain("t2");

        // Coalescing two writes to one address.
        mem_stall = 1'b1;
        do_write(28'h30, {4{32'hD1D1_0030}}, 1);
        do_write(28'h30, {4{32'hD2D2_0030}}, 2);
        wr0 = mem_writes;
        mem_stall = 1'b0;
        wait_drain("t3");
        check_eq("t3_drain_count", data_t'(mem_writes - wr0), data_t'(1));
        check_eq("t3_drain_data",  last_drain_data, {4{32'hD2D2_0030}});

        // Full buffer: a fifth write forces the oldest entry out first.
        fixed_delay = 1;
        drained.delete();
        for (int i = 0; i < 4; i++)
            do_write(addr_t'(32'h40 + i), rand_data(), (i == 0) ? 1 : 2);
        do_write(28'h44, rand_data(), 0);
        check_eq("t4_drains_before_accept", data_t'(drained.size()), data_t'(1));
        wait_drain("t4");
        check_eq("t4_total_drains", data_t'(drained.size()), data_t'(5));
        for (int i = 0; i < 5; i++)
            if (i < drained.size())
                check_eq("t4_drain_order", data_t'(drained[i]), data_t'(32'h40 + i));

        // Read miss bypasses a queued write.
        mem_stall = 1'b1;
        do_write(28'h50, rand_data(), 1);
        c_if.read = 1'b1;
        c_if.addr = 28'h60;
        wait_mem_req("t5_mem_read", 1'b1);
        check_eq("t5_mem_addr",     data_t'(m_if.addr), data_t'(28'h60));
        check_eq("t5_no_mem_write", data_t'(m_if.write), '0);
        mem_stall = 1'b0;
        wait_ready("t5_rd", 50, lat);
        c_if.read = 1'b0;
        check_eq("t5_rdata", c_if.rdata, init_val(28'h60));
        wait_drain("t5");

        // Reset during an outstanding memory read discards queued writes.
        mem_stall = 1'b1;
        do_write(28'h70, rand_data(), 1);
        c_if.read = 1'b1;
        c_if.addr = 28'h61;
        wait_mem_req("t6_mem_read", 1'b1);
        c_if.read = 1'b0;
        rst = 1'b1;
        mq.delete();
        tick();
        rst = 1'b0;
        mem_stall = 1'b0;
        check_eq("t6_mem_read_cleared", data_t'(m_if.read), '0);
        check_eq("t6_wb_empty",         data_t'(wb_empty), data_t'(1));
        check_eq("t6_c_ready",          data_t'(c_if.ready), '0);
        do_read(28'h70, 0, 1'b0);

        // Random traffic over a small address pool to exercise hits and fills.
        rand_delay = 1'b1;
        for (int n = 0; n < 400; n++) begin
            a = addr_t'(32'h100 + $urandom_range(0, 5));
            case ($urandom_range(0, 9))
                0, 1, 2, 3: do_write(a, rand_data(), 0);
                4, 5, 6, 7: do_read(a, 0, 1'b0);
                default:    repeat ($urandom_range(1, 4)) tick();
            endcase
        end
        wait_drain("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
